residue_arbiter_ctrl: RTL

//  Shares one serial residue machine (MSB-first, 1 bit/clk, RES_W-bit residue output)

---
 rtl/residue_arbiter_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/residue_arbiter_ctrl.sv
// Round-robin share of one serial MSB-first residue machine between two requesters; ack (LOAD) to res_valid = WIDTH+2 cycles.
// No queueing: requests seen only in IDLE, requester holds req/data until its ack pulse.
module residue_arbiter_ctrl #(
    parameter int WIDTH = 8,
    parameter int RES_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             res_valid,
    output logic [RES_W-1:0] res_data,
    output logic             res_id,
    output logic             mc_I,
    output logic             mc_reset,
    input  logic [RES_W-1:0] mc_mod
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPT} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] word, word_n;
    logic             id, id_n;
    logic             last, last_n;
    logic             gnt_id;
    logic             ack0_n, ack1_n, busy_n, res_valid_n, res_id_n, mc_I_n, mc_reset_n;
    logic [RES_W-1:0] res_data_n;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        word_n      = word;
        id_n        = id;
        last_n      = last;
        gnt_id      = 1'b0;
        ack0_n      = 1'b0;
        ack1_n      = 1'b0;
        res_valid_n = 1'b0;
        res_data_n  = res_data;
        res_id_n    = res_id;
        mc_I_n      = 1'b0;
        mc_reset_n  = 1'b1;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the side that was not served last wins.
                    gnt_id  = (req0 && req1) ? ~last : req1;
                    state_n = LOAD;
                    id_n    = gnt_id;
                    word_n  = gnt_id ? data1 : data0;
                    ack0_n  = ~gnt_id;
                    ack1_n  = gnt_id;
                    mc_I_n  = word_n[WIDTH-1];
                end
            end
            LOAD: begin
                state_n    = SHIFT;
                cnt_n      = '0;
                mc_reset_n = 1'b0;
                mc_I_n     = word[WIDTH-1];
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = CAPT;
                end else begin
                    // Word shifts left so the next bit to present is always word[WIDTH-2].
                    cnt_n      = cnt + 1'b1;
                    word_n     = word << 1;
                    mc_reset_n = 1'b0;
                    mc_I_n     = word[WIDTH-2];
                end
            end
            CAPT: begin
                state_n     = IDLE;
                res_valid_n = 1'b1;
                res_data_n  = mc_mod;
                res_id_n    = id;
                last_n      = id;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            word      <= '0;
            id        <= 1'b0;
            last      <= 1'b1;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            mc_I      <= 1'b0;
            mc_reset  <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            word      <= word_n;
            id        <= id_n;
            last      <= last_n;
            ack0      <= ack0_n;
            ack1      <= ack1_n;
            busy      <= busy_n;
            res_valid <= res_valid_n;
            res_data  <= res_data_n;
            res_id    <= res_id_n;
            mc_I      <= mc_I_n;
            mc_reset  <= mc_reset_n;
        end
    end

endmodule
